// File: rtl/s1b_fm_checker.sv
// Multi-channel monitor for "$rose(a) ##[MIN_DLY:MAX_DLY] b |=> c" with per-attempt pulses and
// saturating totals. Define S1B_FM_CHECKER_SVA_EN to add the equivalent concurrent assertions.
module s1b_fm_checker #(
    parameter int NCH         = 1,
    parameter int MIN_DLY     = 2,
    parameter int MAX_DLY     = 5,
    parameter int FIRST_MATCH = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   a,
    input  logic [NCH-1:0]   b,
    input  logic [NCH-1:0]   c,
    input  logic             clr_cnt,
    output logic [NCH-1:0]   busy,
    output logic [NCH-1:0]   pass,
    output logic [NCH-1:0]   fail,
    output logic [NCH-1:0]   vacuous,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] vac_cnt
);

    // Age saturates one past the window, or at MIN_DLY when the window is unbounded.
    localparam bit UNBOUNDED = (MAX_DLY == 0);
    localparam int K_SAT_I   = UNBOUNDED ? MIN_DLY : MAX_DLY + 1;
    localparam int KW        = $clog2(K_SAT_I + 1);
    localparam logic [KW-1:0] K_SAT  = KW'(K_SAT_I);
    localparam logic [KW-1:0] K_MIN  = KW'(MIN_DLY);
    localparam logic [KW-1:0] K_LAST = KW'(MAX_DLY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    function automatic logic [5:0] popcnt(input logic [NCH-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int j = 0; j < NCH; j++) begin
            n = n + {5'd0, v[j]};
        end
        return n;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt, input logic [5:0] inc);
        logic [CNT_W+6:0] sum;
        sum = {7'd0, cnt} + {{(CNT_W+1){1'b0}}, inc};
        if (sum > {7'd0, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end else begin
            return sum[CNT_W-1:0];
        end
    endfunction

    logic [NCH-1:0] pass_nx_s;
    logic [NCH-1:0] fail_nx_s;
    logic [NCH-1:0] vac_nx_s;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t        state_q, state_d;
        logic [KW-1:0] k_q, k_d;
        logic          a_prev_q;
        logic          pend_q, pend_d;
        logic          match_q, match_d;
        logic          busy_q, pass_q, fail_q, vac_q;
        logic          pass_d, fail_d, vac_d;
        logic          rose_s, in_win_s, closed_s, hit_s;

        assign rose_s   = a[i] & ~a_prev_q;
        assign in_win_s = (k_q >= K_MIN) && (UNBOUNDED || (k_q <= K_LAST));
        assign closed_s = !UNBOUNDED && (k_q == K_SAT);
        assign hit_s    = in_win_s & b[i];

        // Attempt sequencing; k_q holds the age of the edge currently being evaluated.
        always_comb begin
            state_d = state_q;
            k_d     = k_q;
            pend_d  = 1'b0;
            match_d = match_q;
            pass_d  = 1'b0;
            fail_d  = 1'b0;
            vac_d   = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rose_s) begin
                        state_d = ST_WAIT;
                        k_d     = KW'(1);
                        match_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    k_d = (k_q == K_SAT) ? k_q : k_q + KW'(1);
                    if (FIRST_MATCH != 0) begin
                        if (hit_s) begin
                            state_d = ST_CHECK;
                        end else if (closed_s) begin
                            vac_d   = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else begin
                        // A failing check ends the attempt even while the window is still open.
                        if (pend_q && !c[i]) begin
                            fail_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (closed_s) begin
                            pass_d  = match_q;
                            vac_d   = ~match_q;
                            state_d = ST_IDLE;
                        end else begin
                            pend_d  = hit_s;
                            match_d = match_q | hit_s;
                        end
                    end
                end
                ST_CHECK: begin
                    if (c[i]) begin
                        pass_d = 1'b1;
                    end else begin
                        fail_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Channel state and registered result pulses.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q  <= ST_IDLE;
                k_q      <= {KW{1'b0}};
                a_prev_q <= 1'b0;
                pend_q   <= 1'b0;
                match_q  <= 1'b0;
                busy_q   <= 1'b0;
                pass_q   <= 1'b0;
                fail_q   <= 1'b0;
                vac_q    <= 1'b0;
            end else begin
                state_q  <= state_d;
                k_q      <= k_d;
                a_prev_q <= a[i];
                pend_q   <= pend_d;
                match_q  <= match_d;
                busy_q   <= (state_d != ST_IDLE);
                pass_q   <= pass_d;
                fail_q   <= fail_d;
                vac_q    <= vac_d;
            end
        end

        assign busy[i]      = busy_q;
        assign pass[i]      = pass_q;
        assign fail[i]      = fail_q;
        assign vacuous[i]   = vac_q;
        assign pass_nx_s[i] = pass_d;
        assign fail_nx_s[i] = fail_d;
        assign vac_nx_s[i]  = vac_d;

`ifdef S1B_FM_CHECKER_SVA_EN
        int unsigned sva_fails_s;
        if (FIRST_MATCH != 0) begin : g_sva_fm
            if (UNBOUNDED) begin : g_unb
                a_prop: assert property (@(posedge clk) disable iff (rst)
                    $rose(a[i]) |-> first_match(##[MIN_DLY:$] b[i]) ##1 c[i])
                    else sva_fails_s = sva_fails_s + 1;
            end else begin : g_bnd
                a_prop: assert property (@(posedge clk) disable iff (rst)
                    $rose(a[i]) |-> first_match(##[MIN_DLY:MAX_DLY] b[i]) ##1 c[i])
                    else sva_fails_s = sva_fails_s + 1;
            end
        end else begin : g_sva_at
            if (UNBOUNDED) begin : g_unb
                a_prop: assert property (@(posedge clk) disable iff (rst)
                    $rose(a[i]) ##[MIN_DLY:$] b[i] |=> c[i])
                    else sva_fails_s = sva_fails_s + 1;
            end else begin : g_bnd
                a_prop: assert property (@(posedge clk) disable iff (rst)
                    $rose(a[i]) ##[MIN_DLY:MAX_DLY] b[i] |=> c[i])
                    else sva_fails_s = sva_fails_s + 1;
            end
        end
        // The RTL pulse is visible one edge after the edge at which the assertion fails.
        a_xchk: assert property (@(posedge clk) disable iff (rst)
            fail_q == (sva_fails_s != $past(sva_fails_s)));
`endif
    end

    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] vac_cnt_q, vac_cnt_d;

    // Totals track the pulses being registered this edge, so they move with the pulse.
    always_comb begin
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        vac_cnt_d  = vac_cnt_q;
        if (clr_cnt) begin
            pass_cnt_d = {CNT_W{1'b0}};
            fail_cnt_d = {CNT_W{1'b0}};
            vac_cnt_d  = {CNT_W{1'b0}};
        end else begin
            pass_cnt_d = sat_add(pass_cnt_q, popcnt(pass_nx_s));
            fail_cnt_d = sat_add(fail_cnt_q, popcnt(fail_nx_s));
            vac_cnt_d  = sat_add(vac_cnt_q, popcnt(vac_nx_s));
        end
    end

    // Aggregate counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt_q <= {CNT_W{1'b0}};
            fail_cnt_q <= {CNT_W{1'b0}};
            vac_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            vac_cnt_q  <= vac_cnt_d;
        end
    end

    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign vac_cnt  = vac_cnt_q;

endmodule

// File: tb/tb_s1b_fm_checker.sv
// Directed bench for s1b_fm_checker: four single-channel configurations share a/b/c,
// and a four-channel first-match instance with 2-bit counters covers saturation.
module tb_s1b_fm_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0, clr1 = 1'b0;
    logic [3:0] a4 = 4'd0, b4 = 4'd0, c4 = 4'd0;
    logic clr4 = 1'b0;

    logic busy0, pass0, fail0, vac0;
    logic busy1, pass1, fail1, vac1;
    logic busy2, pass2, fail2, vac2;
    logic busy3, pass3, fail3, vac3;
    logic [15:0] pcnt0, fcnt0, vcnt0, pcnt1, fcnt1, vcnt1;
    logic [15:0] pcnt2, fcnt2, vcnt2, pcnt3, fcnt3, vcnt3;
    logic [3:0] busy4, pass4, fail4, vac4;
    logic [1:0] pcnt4, fcnt4, vcnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // dut0: bounded all-threads (defaults)
    s1b_fm_checker u_dut0 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1), .clr_cnt(clr1),
        .busy(busy0), .pass(pass0), .fail(fail0), .vacuous(vac0),
        .pass_cnt(pcnt0), .fail_cnt(fcnt0), .vac_cnt(vcnt0));
    // dut1: bounded first-match
    s1b_fm_checker #(.FIRST_MATCH(1)) u_dut1 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
        .clr_cnt(clr1), .busy(busy1), .pass(pass1), .fail(fail1), .vacuous(vac1),
        .pass_cnt(pcnt1), .fail_cnt(fcnt1), .vac_cnt(vcnt1));
    // dut2: unbounded all-threads
    s1b_fm_checker #(.MAX_DLY(0)) u_dut2 (.clk(clk), .rst(rst), .a(a1), .b(b1), .c(c1),
        .clr_cnt(clr1), .busy(busy2), .pass(pass2), .fail(fail2), .vacuous(vac2),
        .pass_cnt(pcnt2), .fail_cnt(fcnt2), .vac_cnt(vcnt2));
    // dut3: unbounded first-match
    s1b_fm_checker #(.MAX_DLY(0), .FIRST_MATCH(1)) u_dut3 (.clk(clk), .rst(rst), .a(a1),
        .b(b1), .c(c1), .clr_cnt(clr1), .busy(busy3), .pass(pass3), .fail(fail3),
        .vacuous(vac3), .pass_cnt(pcnt3), .fail_cnt(fcnt3), .vac_cnt(vcnt3));
    // dut4: four channels, first-match, 2-bit counters
    s1b_fm_checker #(.NCH(4), .FIRST_MATCH(1), .CNT_W(2)) u_dut4 (.clk(clk), .rst(rst),
        .a(a4), .b(b4), .c(c4), .clr_cnt(clr4), .busy(busy4), .pass(pass4), .fail(fail4),
        .vacuous(vac4), .pass_cnt(pcnt4), .fail_cnt(fcnt4), .vac_cnt(vcnt4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 with reset released.
    task automatic do_reset();
        rst = 1'b1;
        a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; clr1 = 1'b0;
        a4 = 4'd0; b4 = 4'd0; c4 = 4'd0; clr4 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++; if ({busy0, pass0, fail0, vac0} !== 4'b0000) begin errors++; $display("FAIL reset_flags0 got=%b exp=0000", {busy0, pass0, fail0, vac0}); end
        checks++; if ({pcnt0, fcnt0, vcnt0} !== 48'd0) begin errors++; $display("FAIL reset_cnt0 got=%0h exp=0", {pcnt0, fcnt0, vcnt0}); end
        checks++; if ({busy1, pass1, fail1, vac1} !== 4'b0000) begin errors++; $display("FAIL reset_flags1 got=%b exp=0000", {busy1, pass1, fail1, vac1}); end
        checks++; if ({busy4, pass4, fail4, vac4} !== 16'h0000) begin errors++; $display("FAIL reset_flags4 got=%0h exp=0", {busy4, pass4, fail4, vac4}); end
        checks++; if ({pcnt4, fcnt4, vcnt4} !== 6'd0) begin errors++; $display("FAIL reset_cnt4 got=%0h exp=0", {pcnt4, fcnt4, vcnt4}); end
    endtask

    task automatic test_pass();
        logic [15:0] a_v, b_v, c_v, p0_v, bz0_v, p1_v, bz1_v;
        a_v = 16'h0001; b_v = 16'h0008; c_v = 16'h0010;
        p0_v = 16'h0080; bz0_v = 16'h007E;
        p1_v = 16'h0020; bz1_v = 16'h001E;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            checks++; if (pass0 !== p0_v[n]) begin errors++; $display("FAIL at_pass n=%0d got=%b exp=%b", n, pass0, p0_v[n]); end
            checks++; if (busy0 !== bz0_v[n]) begin errors++; $display("FAIL at_busy n=%0d got=%b exp=%b", n, busy0, bz0_v[n]); end
            checks++; if ((fail0 | vac0) !== 1'b0) begin errors++; $display("FAIL at_nofail n=%0d got=%b exp=0", n, fail0 | vac0); end
            checks++; if (pass1 !== p1_v[n]) begin errors++; $display("FAIL fm_pass n=%0d got=%b exp=%b", n, pass1, p1_v[n]); end
            checks++; if (busy1 !== bz1_v[n]) begin errors++; $display("FAIL fm_busy n=%0d got=%b exp=%b", n, busy1, bz1_v[n]); end
            checks++; if (pass3 !== p1_v[n]) begin errors++; $display("FAIL ufm_pass n=%0d got=%b exp=%b", n, pass3, p1_v[n]); end
            a1 = a_v[n]; b1 = b_v[n]; c1 = c_v[n];
            tick();
        end
        checks++; if (pcnt0 !== 16'd1) begin errors++; $display("FAIL at_pass_cnt got=%0d exp=1", pcnt0); end
        checks++; if (pcnt1 !== 16'd1) begin errors++; $display("FAIL fm_pass_cnt got=%0d exp=1", pcnt1); end
    endtask

    task automatic test_all_threads_fail();
        logic [15:0] a_v, b_v, c_v, f0_v, bz0_v, p1_v, bz1_v;
        a_v = 16'h0001; b_v = 16'h0024; c_v = 16'h0008;
        f0_v = 16'h0080; bz0_v = 16'h007E;
        p1_v = 16'h0010; bz1_v = 16'h000E;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            checks++; if (fail0 !== f0_v[n]) begin errors++; $display("FAIL at_fail n=%0d got=%b exp=%b", n, fail0, f0_v[n]); end
            checks++; if (pass0 !== 1'b0) begin errors++; $display("FAIL at_nopass n=%0d got=%b exp=0", n, pass0); end
            checks++; if (busy0 !== bz0_v[n]) begin errors++; $display("FAIL at_busy2 n=%0d got=%b exp=%b", n, busy0, bz0_v[n]); end
            checks++; if (pass1 !== p1_v[n]) begin errors++; $display("FAIL fm_first n=%0d got=%b exp=%b", n, pass1, p1_v[n]); end
            checks++; if (fail1 !== 1'b0) begin errors++; $display("FAIL fm_nofail n=%0d got=%b exp=0", n, fail1); end
            checks++; if (busy1 !== bz1_v[n]) begin errors++; $display("FAIL fm_busy2 n=%0d got=%b exp=%b", n, busy1, bz1_v[n]); end
            a1 = a_v[n]; b1 = b_v[n]; c1 = c_v[n];
            tick();
        end
        checks++; if (fcnt0 !== 16'd1) begin errors++; $display("FAIL at_fail_cnt got=%0d exp=1", fcnt0); end
        checks++; if (pcnt0 !== 16'd0) begin errors++; $display("FAIL at_pass_cnt2 got=%0d exp=0", pcnt0); end
        checks++; if (pcnt1 !== 16'd1) begin errors++; $display("FAIL fm_pass_cnt2 got=%0d exp=1", pcnt1); end
    endtask

    task automatic test_vacuous();
        logic [15:0] a_v, v_v, bz_v;
        a_v = 16'h0009; v_v = 16'h0080; bz_v = 16'h007E;
        do_reset();
        for (int n = 0; n < 12; n++) begin
            checks++; if (vac0 !== v_v[n]) begin errors++; $display("FAIL at_vac n=%0d got=%b exp=%b", n, vac0, v_v[n]); end
            checks++; if (busy0 !== bz_v[n]) begin errors++; $display("FAIL at_vbusy n=%0d got=%b exp=%b", n, busy0, bz_v[n]); end
            checks++; if ((pass0 | fail0) !== 1'b0) begin errors++; $display("FAIL at_vnopf n=%0d got=%b exp=0", n, pass0 | fail0); end
            checks++; if (vac1 !== v_v[n]) begin errors++; $display("FAIL fm_vac n=%0d got=%b exp=%b", n, vac1, v_v[n]); end
            a1 = a_v[n]; b1 = 1'b0; c1 = 1'b0;
            tick();
        end
        checks++; if (vcnt0 !== 16'd1) begin errors++; $display("FAIL at_vac_cnt got=%0d exp=1", vcnt0); end
    endtask

    task automatic test_unbounded();
        do_reset();
        for (int n = 0; n < 104; n++) begin
            checks++; if ({pass2, fail2, vac2} !== 3'b000) begin errors++; $display("FAIL uat_quiet n=%0d got=%b exp=000", n, {pass2, fail2, vac2}); end
            checks++; if (busy2 !== (n >= 1)) begin errors++; $display("FAIL uat_busy n=%0d got=%b exp=%b", n, busy2, n >= 1); end
            checks++; if (pass3 !== (n == 6)) begin errors++; $display("FAIL ufm_pass2 n=%0d got=%b exp=%b", n, pass3, n == 6); end
            checks++; if (busy3 !== (n >= 1 && n <= 5)) begin errors++; $display("FAIL ufm_busy n=%0d got=%b exp=%b", n, busy3, n >= 1 && n <= 5); end
            a1 = (n == 0); b1 = ((n % 4) == 0); c1 = ((n % 4) == 1);
            tick();
        end
        checks++; if (pcnt2 !== 16'd0) begin errors++; $display("FAIL uat_pass_cnt got=%0d exp=0", pcnt2); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a_v, b_v, c_v, p_v, bz_v;
        // Rose on the deciding edge is dropped.
        a_v = 16'h0009; b_v = 16'h0004; c_v = 16'h0008; p_v = 16'h0010; bz_v = 16'h000E;
        do_reset();
        for (int n = 0; n < 10; n++) begin
            checks++; if (pass1 !== p_v[n]) begin errors++; $display("FAIL b2b_drop_pass n=%0d got=%b exp=%b", n, pass1, p_v[n]); end
            checks++; if (busy1 !== bz_v[n]) begin errors++; $display("FAIL b2b_drop_busy n=%0d got=%b exp=%b", n, busy1, bz_v[n]); end
            a1 = a_v[n]; b1 = b_v[n]; c1 = c_v[n];
            tick();
        end
        // Rose one edge after the deciding edge starts a new attempt.
        a_v = 16'h0011; b_v = 16'h0044; c_v = 16'h0088; p_v = 16'h0110; bz_v = 16'h00EE;
        do_reset();
        for (int n = 0; n < 11; n++) begin
            checks++; if (pass1 !== p_v[n]) begin errors++; $display("FAIL b2b_next_pass n=%0d got=%b exp=%b", n, pass1, p_v[n]); end
            checks++; if (busy1 !== bz_v[n]) begin errors++; $display("FAIL b2b_next_busy n=%0d got=%b exp=%b", n, busy1, bz_v[n]); end
            a1 = a_v[n]; b1 = b_v[n]; c1 = c_v[n];
            tick();
        end
        checks++; if (pcnt1 !== 16'd2) begin errors++; $display("FAIL b2b_pass_cnt got=%0d exp=2", pcnt1); end
    endtask

    task automatic test_saturate();
        logic [3:0] exp_p;
        logic [1:0] exp_c;
        do_reset();
        for (int n = 0; n < 20; n++) begin
            exp_p = (n == 4) ? 4'b0011 : ((n == 10 || n == 18) ? 4'b1111 : 4'b0000);
            exp_c = (n < 4) ? 2'd0 : ((n < 10) ? 2'd2 : ((n < 13) ? 2'd3 : 2'd0));
            checks++; if (pass4 !== exp_p) begin errors++; $display("FAIL sat_pass n=%0d got=%b exp=%b", n, pass4, exp_p); end
            checks++; if (pcnt4 !== exp_c) begin errors++; $display("FAIL sat_cnt n=%0d got=%0d exp=%0d", n, pcnt4, exp_c); end
            checks++; if ((fail4 | vac4) !== 4'b0000) begin errors++; $display("FAIL sat_quiet n=%0d got=%b exp=0000", n, fail4 | vac4); end
            a4 = (n == 0) ? 4'b0011 : ((n == 6 || n == 14) ? 4'b1111 : 4'b0000);
            b4 = (n == 2 || n == 8 || n == 16) ? 4'b1111 : 4'b0000;
            c4 = (n == 3 || n == 9 || n == 17) ? 4'b1111 : 4'b0000;
            clr4 = (n == 12 || n == 17);
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int n = 0; n < 4; n++) begin
            a1 = (n == 0); b1 = (n == 3); c1 = 1'b0;
            tick();
        end
        checks++; if ({busy0, busy1} !== 2'b11) begin errors++; $display("FAIL mid_busy_pre got=%b exp=11", {busy0, busy1}); end
        a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
        #2 rst = 1'b1;
        #1;
        checks++; if ({busy0, busy1} !== 2'b00) begin errors++; $display("FAIL mid_busy_async got=%b exp=00", {busy0, busy1}); end
        checks++; if ({pass1, fail1, pcnt1} !== 18'd0) begin errors++; $display("FAIL mid_pulse_async got=%0h exp=0", {pass1, fail1, pcnt1}); end
        tick();
        tick();
        rst = 1'b0; c1 = 1'b0;
        // a is still high, so the first edge after reset is a rose.
        for (int n = 0; n < 6; n++) begin
            checks++; if (busy0 !== (n >= 1)) begin errors++; $display("FAIL mid_rose_busy n=%0d got=%b exp=%b", n, busy0, n >= 1); end
            checks++; if ({pass0, fail0, vac0, pass1, fail1, vac1} !== 6'd0) begin errors++; $display("FAIL mid_nopulse n=%0d got=%b exp=000000", n, {pass0, fail0, vac0, pass1, fail1, vac1}); end
            tick();
        end
        checks++; if (pcnt1 !== 16'd0) begin errors++; $display("FAIL mid_pass_cnt got=%0d exp=0", pcnt1); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_all_threads_fail();
        test_vacuous();
        test_unbounded();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
